ahb_master_if: RTL
==================

// Module: ahb_master_if
// PURPOSE
//  AHB-Lite initiator that turns one command (address, size, beat count, direction) into a
//  SINGLE or INCR-type burst on the AHB bus. It is the counterpart that drives the SRAM
//  controller slave. Write data is pulled from a show-ahead source; read data is pushed out
//  one beat at a time. It honours hready wait states and two-cycle ERROR responses.
// PARAMETERS
//  MAX_LEN  16  largest beat count accepted per command
//  LEN_W    5   width of cmd_len; must hold MAX_LEN
// PORTS
//  hclk         in   1      bus clock; every register updates on its rising edge
//  hreset       in   1      synchronous, active-high reset
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      block idle and can accept a command
//  cmd_write    in   1      1 = write burst, 0 = read burst
//  cmd_addr     in   32     start byte address
//  cmd_size     in   3      AHB hsize code; only 0, 1 and 2 are legal
//  cmd_len      in   LEN_W  number of beats, 1..MAX_LEN
//  wdata        in   32     current write beat; held stable by the source (show-ahead)
//  wdata_ready  out  1      write beat consumed this cycle; source advances
//  rdata        out  32     read beat (equals hrdata)
//  rdata_valid  out  1      rdata valid this cycle
//  done         out  1      one-cycle pulse: command finished
//  err          out  1      qualifies done: command rejected or aborted by ERROR
//  haddr        out  32     AHB address
//  htrans       out  2      IDLE=00, NONSEQ=10, SEQ=11; BUSY is never driven
//  hwrite       out  1      AHB direction
//  hsize        out  3      AHB size
//  hburst       out  3      AHB burst type
//  hwdata       out  32     AHB write data
//  hrdata       in   32     AHB read data
//  hready       in   1      AHB ready, from the slave response mux
//  hresp        in   2      AHB response; 00 = OKAY, 01 = ERROR
// BEHAVIOUR
//  Reset values
//   - cmd_ready=1; htrans=IDLE; haddr, hwrite, hsize, hburst, hwdata = 0.
//   - done, err, rdata_valid, wdata_ready = 0.
//   - Reset during a burst abandons it on the next edge. No done pulse is produced.
//  Command accept
//   - A command is accepted at edge T when cmd_valid & cmd_ready. cmd_ready drops at T+1.
//  Rejection (checked at accept)
//   - A command is rejected if any of these holds:
//     - cmd_len == 0 or cmd_len > MAX_LEN;
//     - cmd_size > 2;
//     - cmd_addr is not aligned to 1<<cmd_size;
//     - cmd_addr[9:0] + (cmd_len << cmd_size) > 1024 (the burst would cross a 1KB boundary).
//   - On rejection: no bus activity; done=1 and err=1 at T+1; cmd_ready=1 at T+2.
//  hburst encoding
//   - len 1 -> SINGLE (000); 4 -> INCR4 (011); 8 -> INCR8 (101); 16 -> INCR16 (111);
//     any other length -> INCR (001).
//   - hburst, hsize and hwrite are held constant for the whole burst.
//  States
//   - IDLE: waiting for a command.
//   - ADDR: first address phase.
//   - BURST: overlapping address and data phases.
//   - LAST: final data phase only.
//   - ABORT: error in progress.
//  Pipeline
//   - T+1: haddr=cmd_addr, htrans=NONSEQ.
//   - An address phase is taken on any edge with hready=1.
//   - After each taken address phase: haddr += 1<<size; htrans=SEQ until all beats are
//     issued, then htrans=IDLE.
//   - The data phase of beat n follows the cycle in which its address phase was taken.
//   - hready=0 holds every output, including haddr/htrans, unchanged.
//  Data
//   - During a write data phase: hwdata = wdata; wdata_ready = hready.
//   - During a read data phase: rdata = hrdata; rdata_valid = hready & (hresp == OKAY).
//   - Outside a data phase: hwdata=0; wdata_ready=0; rdata_valid=0.
//  Completion
//   - The final data phase completes with hready=1; done=1 and err=0 on the next cycle.
//   - cmd_ready=1 on that same cycle.
//   - With zero wait states, done is at T+2+len.
//  Error response
//   - Trigger: hresp=ERROR seen with hready=0.
//   - Next cycle: htrans=IDLE, and no further beats are issued.
//   - No rdata_valid or wdata_ready for the errored beat.
//   - The cycle after hready returns high: done=1, err=1, cmd_ready=1.
//  Simultaneous events
//   - Reset has priority over everything.
//   - A new cmd_valid while busy is ignored (cmd_ready=0).
// TESTING
//  1. Write, addr=0x100, size=2, len=1, hready=1 -> T+1: NONSEQ, haddr=0x100, hburst=000;
//     T+2: hwdata=wdata, wdata_ready=1; T+3: done=1, err=0.
//  2. Read, addr=0x40, size=2, len=4 -> haddr 0x40/44/48/4C; htrans NONSEQ,SEQ,SEQ,SEQ;
//     hburst=011; four rdata_valid pulses in order; done at T+6.
//  3. Case 2 with hready=0 for 2 cycles on beat 2 -> haddr/htrans frozen; no duplicate
//     rdata_valid; done at T+8.
//  4. Write len=8, size=1, slave answers ERROR on beat 3 -> htrans=IDLE next cycle; exactly
//     2 wdata_ready pulses; done=1, err=1.
//  5. Rejects, each -> done=1, err=1 at T+1, htrans stays IDLE:
//     addr=0x3F8, size=2, len=4 (1KB crossing); addr=0x101, size=1 (misaligned);
//     len=0; size=3.
//  6. hreset=1 mid-INCR16 read -> next edge: htrans=IDLE, cmd_ready=1, no done;
//     a fresh command then runs normally.

Source files
------------

// File: rtl/ahb_master_if_if.sv
// Command, data-stream and AHB-Lite signal bundle for ahb_master_if.
// master: the initiator's view; slave: the command source and bus slave's view.
interface ahb_master_if_if #(
   parameter int LEN_W = 5
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_write;
   logic [31:0]      cmd_addr;
   logic [2:0]       cmd_size;
   logic [LEN_W-1:0] cmd_len;
   logic [31:0]      wdata;
   logic             wdata_ready;
   logic [31:0]      rdata;
   logic             rdata_valid;
   logic             done;
   logic             err;
   logic [31:0]      haddr;
   logic [1:0]       htrans;
   logic             hwrite;
   logic [2:0]       hsize;
   logic [2:0]       hburst;
   logic [31:0]      hwdata;
   logic [31:0]      hrdata;
   logic             hready;
   logic [1:0]       hresp;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len,
      input  wdata, hrdata, hready, hresp,
      output cmd_ready, wdata_ready, rdata, rdata_valid, done, err,
      output haddr, htrans, hwrite, hsize, hburst, hwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len,
      output wdata, hrdata, hready, hresp,
      input  cmd_ready, wdata_ready, rdata, rdata_valid, done, err,
      input  haddr, htrans, hwrite, hsize, hburst, hwdata
   );
endinterface

// File: rtl/ahb_master_if.sv
// AHB-Lite initiator: one command becomes a SINGLE/INCR burst.
// Handles hready wait states and two-cycle ERROR responses.
module ahb_master_if #(
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = 5
) (
   input logic hclk,
   input logic hreset,
   ahb_master_if_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_BURST, S_LAST, S_ABORT
   } state_t;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_ERR  = 2'b01;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] left_q, left_d;
   logic [31:0]      haddr_q, haddr_d;
   logic [1:0]       htrans_q, htrans_d;
   logic             hwrite_q, hwrite_d;
   logic [2:0]       hsize_q, hsize_d;
   logic [2:0]       hburst_q, hburst_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             rej_q, rej_d;
   logic             take;
   logic             bad_cmd;
   logic             misal;
   logic [11:0]      span;
   logic [2:0]       burst_code;
   logic             dphase;

   // validate the offered command and pick its burst encoding
   always_comb begin
      span = 12'(bus.cmd_addr[9:0]) + (12'(bus.cmd_len) << bus.cmd_size);
      misal = ((bus.cmd_size == 3'd1) && bus.cmd_addr[0]) ||
              ((bus.cmd_size == 3'd2) && (bus.cmd_addr[1:0] != 2'b00));
      bad_cmd = (bus.cmd_len == '0) ||
                (int'(bus.cmd_len) > MAX_LEN) ||
                (bus.cmd_size > 3'd2) ||
                misal ||
                (span > 12'd1024);
      case (bus.cmd_len)
         LEN_W'(1):  burst_code = 3'b000;
         LEN_W'(4):  burst_code = 3'b011;
         LEN_W'(8):  burst_code = 3'b101;
         LEN_W'(16): burst_code = 3'b111;
         default:    burst_code = 3'b001;
      endcase
   end

   // next-state and next register values for the burst sequencer
   always_comb begin
      state_d  = state_q;
      left_d   = left_q;
      haddr_d  = haddr_q;
      htrans_d = htrans_q;
      hwrite_d = hwrite_q;
      hsize_d  = hsize_q;
      hburst_d = hburst_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      rej_d    = 1'b0;
      take     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid && !rej_q) begin
               if (bad_cmd) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
                  rej_d  = 1'b1;
               end else begin
                  state_d  = S_ADDR;
                  left_d   = bus.cmd_len;
                  haddr_d  = bus.cmd_addr;
                  htrans_d = TR_NONSEQ;
                  hwrite_d = bus.cmd_write;
                  hsize_d  = bus.cmd_size;
                  hburst_d = burst_code;
               end
            end
         end
         S_ADDR: take = bus.hready;
         S_BURST, S_LAST: begin
            if (!bus.hready && (bus.hresp == RESP_ERR)) begin
               state_d  = S_ABORT;
               htrans_d = TR_IDLE;
            end else if (bus.hready) begin
               if (state_q == S_LAST) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  take = 1'b1;
               end
            end
         end
         S_ABORT: begin
            if (bus.hready) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (take) begin
         left_d  = left_q - LEN_W'(1);
         haddr_d = haddr_q + (32'd1 << hsize_q);
         if (left_q == LEN_W'(1)) begin
            state_d  = S_LAST;
            htrans_d = TR_IDLE;
         end else begin
            state_d  = S_BURST;
            htrans_d = TR_SEQ;
         end
      end
   end

   // state and bus registers, synchronous reset
   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q  <= S_IDLE;
         left_q   <= '0;
         haddr_q  <= '0;
         htrans_q <= TR_IDLE;
         hwrite_q <= 1'b0;
         hsize_q  <= '0;
         hburst_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rej_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         left_q   <= left_d;
         haddr_q  <= haddr_d;
         htrans_q <= htrans_d;
         hwrite_q <= hwrite_d;
         hsize_q  <= hsize_d;
         hburst_q <= hburst_d;
         done_q   <= done_d;
         err_q    <= err_d;
         rej_q    <= rej_d;
      end
   end

   assign dphase = (state_q == S_BURST) || (state_q == S_LAST);

   assign bus.cmd_ready   = (state_q == S_IDLE) && !rej_q;
   assign bus.haddr       = haddr_q;
   assign bus.htrans      = htrans_q;
   assign bus.hwrite      = hwrite_q;
   assign bus.hsize       = hsize_q;
   assign bus.hburst      = hburst_q;
   assign bus.done        = done_q;
   assign bus.err         = err_q;
   assign bus.hwdata      = (dphase && hwrite_q) ? bus.wdata : 32'd0;
   assign bus.wdata_ready = dphase && hwrite_q && bus.hready;
   assign bus.rdata       = bus.hrdata;
   assign bus.rdata_valid = dphase && !hwrite_q && bus.hready &&
                            (bus.hresp == RESP_OKAY);

endmodule
